// File: rtl/warp_pkg.sv
// warp_pkg: shared warp lifecycle types and default sizing for the ready tracker.
package warp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, ISSUED = 2'd2, BLOCKED = 2'd3} warp_state_t;
  localparam int DEF_NUM_WARPS = 16;
  localparam int DEF_WARPID_DEPTH = $clog2(DEF_NUM_WARPS);
endpackage

// File: rtl/warp_state_fsm.sv
// warp_state_fsm: lifecycle state of a single warp plus a flag for events that do not fit its state.
module warp_state_fsm
  import warp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_i,
  input  logic        issue_i,
  input  logic        wb_i,
  input  logic        exit,
  input  logic        mem,
  input  logic        ret_i,
  output warp_state_t state,
  output warp_state_t nxt,
  output logic        illegal
);
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // exit wins over mem on writeback
  always_comb
    nxt = (state == IDLE    && launch_i) ? READY :
          (state == READY   && issue_i)  ? ISSUED :
          (state == ISSUED  && wb_i)     ? (exit ? IDLE : mem ? BLOCKED : READY) :
          (state == BLOCKED && ret_i)    ? READY : state;
  always_comb
    illegal = (launch_i && state != IDLE) || (issue_i && state != READY) ||
              (wb_i && state != ISSUED) || (ret_i && state != BLOCKED);
endmodule

// File: rtl/warp_ready_tracker.sv
// warp_ready_tracker: per-warp lifecycle tracking that feeds the scheduler's ready vector.
module warp_ready_tracker
  import warp_pkg::*;
#(
  parameter int NUM_WARPS    = DEF_NUM_WARPS,
  parameter int WARPID_DEPTH = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    launch,
  input  logic [NUM_WARPS-1:0]    launch_mask,
  input  logic                    issue_valid,
  input  logic [WARPID_DEPTH-1:0] issue_warp,
  input  logic                    wb_valid,
  input  logic [WARPID_DEPTH-1:0] wb_warp,
  input  logic                    wb_exit,
  input  logic                    wb_mem,
  input  logic                    mem_ret_valid,
  input  logic [WARPID_DEPTH-1:0] mem_ret_warp,
  output logic [NUM_WARPS-1:0]    ready,
  output logic [WARPID_DEPTH:0]   active_count,
  output logic                    all_idle,
  output logic                    err
);
  warp_state_t state [NUM_WARPS];
  warp_state_t nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] illegal;
  logic [WARPID_DEPTH:0] cnt;
  logic bad_id;
  for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
    warp_state_fsm u_fsm (
      .clk(clk),
      .rst(rst),
      .launch_i(launch && launch_mask[i]),
      .issue_i(issue_valid && issue_warp == WARPID_DEPTH'(i)),
      .wb_i(wb_valid && wb_warp == WARPID_DEPTH'(i)),
      .exit(wb_exit),
      .mem(wb_mem),
      .ret_i(mem_ret_valid && mem_ret_warp == WARPID_DEPTH'(i)),
      .state(state[i]),
      .nxt(nxt[i]),
      .illegal(illegal[i])
    );
    assign ready[i] = state[i] == READY;
  end
  // ids past NUM_WARPS only exist when NUM_WARPS is not a power of two
  always_comb
    bad_id = (issue_valid && int'(issue_warp) >= NUM_WARPS) ||
             (wb_valid && int'(wb_warp) >= NUM_WARPS) ||
             (mem_ret_valid && int'(mem_ret_warp) >= NUM_WARPS);
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_WARPS; k++)
      cnt = cnt + (WARPID_DEPTH+1)'(nxt[k] != IDLE);
  end
  always_ff @(posedge clk) begin
    active_count <= rst ? '0 : cnt;
    all_idle     <= rst ? 1'b1 : cnt == '0;
    err          <= rst ? 1'b0 : err || |illegal || bad_id;
  end
endmodule
